// File: rtl/aes128_inv_iter_pkg.sv
// -----------------------------------------------------------------------------
// aes128_pkg
// Shared definitions for the iterative AES-128 inverse cipher:
//   - NR round count, round-constant table, FSM state enum
//   - GF(2^8) helpers (xtime, gmul, multiplicative inverse)
//   - forward / inverse S-box byte functions (wrapped by the S-box modules)
//   - ShiftRows / InvShiftRows byte permutations, InvMixColumns, RotWord
// Byte ordering of every 128-bit block: MSB = byte 0, column-major state
// (byte k sits at row k%4, column k/4).
// -----------------------------------------------------------------------------
package aes128_pkg;

    localparam int NR = 10;

    // Indexed directly by the 4-bit round counter; only entries 1..10 are
    // meaningful, the rest pad the table so any counter value is in range.
    localparam logic [7:0] RCON [0:15] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
        8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        KEYEXP = 2'd1,
        ROUND  = 2'd2,
        DONE   = 2'd3
    } state_t;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // a^254 == a^-1 in GF(2^8); maps 0 to 0 as AES requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h01;
        p = a;
        for (int i = 1; i < 8; i++) begin
            p = gmul(p, p);
            r = gmul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox_fwd(input logic [7:0] a);
        logic [7:0] x;
        x = gf_inv(a);
        return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]}
                 ^ {x[3:0], x[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] sbox_inv(input logic [7:0] s);
        logic [7:0] x;
        x = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
        return gf_inv(x);
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c-r+4)%4)) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
            o[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
            o[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
            o[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
        end
        return o;
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/aes128_inv_iter_if.sv
// -----------------------------------------------------------------------------
// aes128_inv_iter_if
// Request/response bundle of the AES-128 inverse cipher.
//   in_valid/in_ready/ct/key : request port (ciphertext + cipher key)
//   out_valid/out_ready/pt   : response port (plaintext)
//   busy                     : block is expanding the key or running rounds
// master = requester/consumer side, slave = the cipher block.
// -----------------------------------------------------------------------------
interface aes128_inv_iter_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] ct;
    logic [127:0] key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] pt;
    logic         busy;

    modport master (
        output in_valid, ct, key, out_ready,
        input  in_ready, out_valid, pt, busy
    );

    modport slave (
        input  in_valid, ct, key, out_ready,
        output in_ready, out_valid, pt, busy
    );
endinterface

// File: rtl/aes128_inv_iter_sbox.sv
// -----------------------------------------------------------------------------
// aes_inv_sbox / aes_fwd_sbox
// Combinational 8-bit AES S-boxes.
//   din  : input byte
//   dout : substituted byte (inverse S-box or forward S-box respectively)
// -----------------------------------------------------------------------------
module aes_inv_sbox
    import aes128_pkg::*;
(
    input  logic [7:0] din,
    output logic [7:0] dout
);
    assign dout = sbox_inv(din);
endmodule

module aes_fwd_sbox
    import aes128_pkg::*;
(
    input  logic [7:0] din,
    output logic [7:0] dout
);
    assign dout = sbox_fwd(din);
endmodule

// File: rtl/aes128_inv_iter.sv
// -----------------------------------------------------------------------------
// aes128_inv_iter
// Iterative AES-128 inverse cipher: one inverse round per clock, inverse key
// schedule computed on the fly (rk10 is first re-derived from the cipher key,
// then walked back rk9..rk0 while the rounds run). No round-key storage.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : aes128_inv_iter_if.slave (in_valid/in_ready/ct/key request,
//          out_valid/out_ready/pt response, busy status)
// Latency: out_valid rises 21 edges after the accepting edge.
// Optional macro AES128_INV_KEY_CACHE_EN: remembers the last expanded key and
// its rk10; a request with the same key skips KEYEXP (latency 11 edges).
// -----------------------------------------------------------------------------
module aes128_inv_iter
    import aes128_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    aes128_inv_iter_if.slave bus
);

    localparam logic [3:0] CNT_LAST = 4'(NR);

    state_t       state, state_nxt;
    logic [3:0]   cnt;
    logic [127:0] s_reg;
    logic [127:0] rk_reg;
    logic [127:0] pt_reg;
    logic         out_valid_r;
    logic         cache_hit;

    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  sub_in, sub_out;
    logic [31:0]  rcon_w;
    logic [127:0] fwd_rk, inv_rk;
    logic [127:0] isr, isb, round_mid, round_imc;

    assign {w0, w1, w2, w3} = rk_reg;
    assign rcon_w = {RCON[cnt], 24'h0};

    // One shared set of four forward S-boxes: the forward step substitutes
    // RotWord(w3), the inverse step substitutes RotWord(w3 ^ w2) (= new w3).
    assign sub_in = (state == ROUND) ? (w3 ^ w2) : w3;

    for (genvar i = 0; i < 4; i++) begin : g_sub
        aes_fwd_sbox u_fwd_sbox (
            .din  (rot_word(sub_in)[31-8*i -: 8]),
            .dout (sub_out[31-8*i -: 8])
        );
    end

    always_comb begin
        logic [31:0] f0, f1, f2, f3;
        logic [31:0] v3, v2, v1, v0;
        f0 = w0 ^ sub_out ^ rcon_w;
        f1 = w1 ^ f0;
        f2 = w2 ^ f1;
        f3 = w3 ^ f2;
        fwd_rk = {f0, f1, f2, f3};
        v3 = w3 ^ w2;
        v2 = w2 ^ w1;
        v1 = w1 ^ w0;
        v0 = w0 ^ sub_out ^ rcon_w;
        inv_rk = {v0, v1, v2, v3};
    end

    assign isr = inv_shift_rows(s_reg);

    for (genvar i = 0; i < 16; i++) begin : g_isb
        aes_inv_sbox u_inv_sbox (
            .din  (isr[127-8*i -: 8]),
            .dout (isb[127-8*i -: 8])
        );
    end

    assign round_mid = isb ^ rk_reg;
    assign round_imc = inv_mix_columns(round_mid);

`ifdef AES128_INV_KEY_CACHE_EN
    logic [127:0] cache_key;
    logic [127:0] cache_rk10;
    logic         cache_vld;

    assign cache_hit = cache_vld && (bus.key == cache_key);

    // The key is captured on a missing accept (cache_vld dropped until the
    // expansion completes), rk10 at the last KEYEXP edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            cache_key  <= '0;
            cache_rk10 <= '0;
            cache_vld  <= 1'b0;
        end else if (state == IDLE && bus.in_valid && !cache_hit) begin
            cache_key <= bus.key;
            cache_vld <= 1'b0;
        end else if (state == KEYEXP && cnt == CNT_LAST) begin
            cache_rk10 <= fwd_rk;
            cache_vld  <= 1'b1;
        end
    end
`else
    assign cache_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.in_valid) state_nxt = cache_hit ? ROUND : KEYEXP;
            KEYEXP:  if (cnt == CNT_LAST) state_nxt = ROUND;
            ROUND:   if (cnt == 4'd0) state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // In ROUND the counter walks 10..0: 10 is the initial AddRoundKey,
    // 9..1 full inverse rounds, 0 the final round without InvMixColumns.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            s_reg       <= '0;
            rk_reg      <= '0;
            pt_reg      <= '0;
            out_valid_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        s_reg <= bus.ct;
`ifdef AES128_INV_KEY_CACHE_EN
                        if (cache_hit) begin
                            rk_reg <= cache_rk10;
                            cnt    <= CNT_LAST;
                        end else begin
                            rk_reg <= bus.key;
                            cnt    <= 4'd1;
                        end
`else
                        rk_reg <= bus.key;
                        cnt    <= 4'd1;
`endif
                    end
                end
                KEYEXP: begin
                    rk_reg <= fwd_rk;
                    if (cnt != CNT_LAST) cnt <= cnt + 4'd1;
                end
                ROUND: begin
                    if (cnt == CNT_LAST) begin
                        s_reg <= s_reg ^ rk_reg;
                    end else if (cnt != 4'd0) begin
                        s_reg <= round_imc;
                    end else begin
                        pt_reg      <= round_mid;
                        out_valid_r <= 1'b1;
                    end
                    if (cnt != 4'd0) begin
                        rk_reg <= inv_rk;
                        cnt    <= cnt - 4'd1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) out_valid_r <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.busy      = (state == KEYEXP) || (state == ROUND);
    assign bus.out_valid = out_valid_r;
    assign bus.pt        = pt_reg;

endmodule

// File: tb/tb_aes128_inv_iter.sv
// -----------------------------------------------------------------------------
// tb_aes128_inv_iter
// Self-checking bench for aes128_inv_iter: known-answer vector table, hand
// sequences for backpressure and mid-round reset, and random key/plaintext
// pairs encrypted by a byte-array forward AES-128 model and decrypted by the
// DUT. Honours AES128_INV_KEY_CACHE_EN for the expected latency.
// -----------------------------------------------------------------------------
module tb_aes128_inv_iter;

    logic clk;
    logic rst;

    aes128_inv_iter_if bus ();

    aes128_inv_iter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [7:0]   sb [256];
    bit           cvld;
    logic [127:0] ckey;

    typedef struct packed {
        logic [127:0] ct;
        logic [127:0] key;
        logic [127:0] pt;
    } vec_t;

    vec_t vt [3];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] xt(input logic [7:0] a);
        return (a[7]) ? ((a << 1) ^ 8'h1b) : (a << 1);
    endfunction

    function automatic logic [7:0] rl(input logic [7:0] a, input int n);
        logic [7:0] r;
        r = a;
        for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    // S-box built by walking generator 3 and its inverse through the field.
    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        repeat (255) begin
            p = p ^ (p << 1) ^ ((p[7]) ? 8'h1b : 8'h00);
            q = q ^ (q << 1);
            q = q ^ (q << 2);
            q = q ^ (q << 4);
            if (q[7]) q = q ^ 8'h09;
            x = q ^ rl(q, 1) ^ rl(q, 2) ^ rl(q, 3) ^ rl(q, 4);
            sb[p] = x ^ 8'h63;
        end
        sb[0] = 8'h63;
    endtask

    function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] key);
        logic [7:0] w [176];
        logic [7:0] s [16];
        logic [7:0] t [16];
        logic [7:0] tmp [4];
        logic [7:0] rc, t0, a0, a1, a2, a3;
        logic [127:0] o;
        for (int i = 0; i < 16; i++) begin
            w[i] = key[127-8*i -: 8];
            s[i] = pt[127-8*i -: 8];
        end
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            for (int j = 0; j < 4; j++) tmp[j] = w[4*(i-1)+j];
            if (i % 4 == 0) begin
                t0 = tmp[0];
                tmp[0] = sb[tmp[1]] ^ rc;
                tmp[1] = sb[tmp[2]];
                tmp[2] = sb[tmp[3]];
                tmp[3] = sb[t0];
                rc = xt(rc);
            end
            for (int j = 0; j < 4; j++) w[4*i+j] = w[4*(i-4)+j] ^ tmp[j];
        end
        for (int r = 0; r <= 10; r++) begin
            if (r > 0) begin
                for (int i = 0; i < 16; i++) s[i] = sb[s[i]];
                for (int c = 0; c < 4; c++)
                    for (int rw = 0; rw < 4; rw++) t[rw+4*c] = s[rw+4*((c+rw)%4)];
                for (int i = 0; i < 16; i++) s[i] = t[i];
                if (r < 10) begin
                    for (int c = 0; c < 4; c++) begin
                        a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                        s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                        s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                        s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                        s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                    end
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[16*r+i];
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
        return o;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        cvld = 1'b0;
    endtask

    // Called #1 after a rising edge. Issues one request, measures latency,
    // checks status during processing, the plaintext, stall stability and
    // the return to IDLE after the response handshake.
    task automatic run_req(input logic [127:0] c, input logic [127:0] k, input logic [127:0] e,
                           input int stall, input bit early, input bit junk, input string nm);
        int n, w, lat_exp;
        bit bad;
        logic [127:0] held;
        w = 0;
        while (!bus.in_ready && w < 50) begin
            @(posedge clk); #1; w++;
        end
        chk({nm, " ready"}, 128'(bus.in_ready), 128'd1);
        bus.in_valid  = 1'b1;
        bus.ct        = c;
        bus.key       = k;
        bus.out_ready = early;
        lat_exp = 21;
`ifdef AES128_INV_KEY_CACHE_EN
        if (cvld && k == ckey) lat_exp = 11;
        else begin
            cvld = 1'b1;
            ckey = k;
        end
`endif
        @(posedge clk); #1;
        bus.in_valid = junk;
        if (junk) begin
            bus.ct  = rnd128();
            bus.key = rnd128();
        end
        n = 0;
        bad = 1'b0;
        while (!bus.out_valid && n < 60) begin
            if (!bus.busy || bus.in_ready) bad = 1'b1;
            @(posedge clk); #1;
            n++;
        end
        bus.in_valid = 1'b0;
        chk({nm, " latency"}, 128'(n), 128'(lat_exp));
        chk({nm, " busy"}, 128'(bad), 128'd0);
        chk({nm, " pt"}, bus.pt, e);
        if (early) begin
            @(posedge clk); #1;
        end else begin
            bad = 1'b0;
            held = bus.pt;
            for (int i = 0; i < stall; i++) begin
                @(posedge clk); #1;
                if (bus.pt !== held || !bus.out_valid || bus.in_ready || bus.busy) bad = 1'b1;
            end
            chk({nm, " stall"}, 128'(bad), 128'd0);
            @(negedge clk);
            bus.out_ready = 1'b1;
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b0;
        chk({nm, " release"}, 128'({bus.in_ready, bus.out_valid}), 128'(2'b10));
    endtask

    initial begin
        logic [127:0] k, p;
        bit bad;
        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.ct  = '0;
        bus.key = '0;
        cvld = 1'b0;
        ckey = '0;
        build_sbox();

        vt[0] = '{ct: 128'h69c4e0d86a7b0430d8cdb78070b4c55a, key: 128'h000102030405060708090a0b0c0d0e0f,
                  pt: 128'h00112233445566778899aabbccddeeff};
        vt[1] = '{ct: 128'h3925841d02dc09fbdc118597196a0b32, key: 128'h2b7e151628aed2a6abf7158809cf4f3c,
                  pt: 128'h3243f6a8885a308d313198a2e0370734};
        vt[2] = '{ct: 128'h66e94bd4ef8a2c3b884cfa59ca342b2e, key: 128'h0,
                  pt: 128'h0};

        do_reset();
        chk("reset in_ready", 128'(bus.in_ready), 128'd1);
        chk("reset out_valid", 128'(bus.out_valid), 128'd0);
        chk("reset busy", 128'(bus.busy), 128'd0);
        chk("reset pt", bus.pt, 128'd0);

        // out_ready high while idle must not disturb anything
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 bus.out_ready = 1'b0;
        chk("idle out_ready", 128'({bus.in_ready, bus.out_valid, bus.busy}), 128'(3'b100));

        for (int i = 0; i < 3; i++)
            run_req(vt[i].ct, vt[i].key, vt[i].pt, 2, 1'b0, 1'b0, $sformatf("vec%0d", i));

        // Backpressure, then an immediate repeat of the same key, then a new key.
        run_req(vt[0].ct, vt[0].key, vt[0].pt, 50, 1'b0, 1'b1, "bp c1");
        run_req(vt[0].ct, vt[0].key, vt[0].pt, 0, 1'b0, 1'b0, "c1 again");
        run_req(vt[1].ct, vt[1].key, vt[1].pt, 0, 1'b1, 1'b0, "appb key");

        // Reset sampled at E15 (mid-ROUND) aborts the request.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.ct  = vt[0].ct;
        bus.key = vt[0].key;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (14) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        cvld = 1'b0;
        chk("abort state", 128'({bus.in_ready, bus.out_valid, bus.busy}), 128'(3'b100));
        chk("abort pt", bus.pt, 128'd0);
        bad = 1'b0;
        repeat (30) begin
            @(posedge clk); #1;
            if (bus.out_valid || !bus.in_ready) bad = 1'b1;
        end
        chk("abort quiet", 128'(bad), 128'd0);
        run_req(vt[0].ct, vt[0].key, vt[0].pt, 1, 1'b0, 1'b0, "after abort");

        for (int i = 0; i < 1000; i++) begin
            k = rnd128();
            p = rnd128();
            run_req(aes_enc(p, k), k, p, $urandom_range(0, 3), ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 7) == 0), $sformatf("rand%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
